// File: rtl/canvas_streamer_if.sv
// Pixel stream handshake between the canvas streamer and the
// network input layer.
interface canvas_streamer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] Pixel_Out;
  logic [9:0]       Pixel_Index;
  logic             Pixel_Valid;
  logic             Pixel_Ready;
  logic             Pixel_Last;

  modport master (
    output Pixel_Out,
    output Pixel_Index,
    output Pixel_Valid,
    output Pixel_Last,
    input  Pixel_Ready
  );

  modport slave (
    input  Pixel_Out,
    input  Pixel_Index,
    input  Pixel_Valid,
    input  Pixel_Last,
    output Pixel_Ready
  );
endinterface

// File: rtl/canvas_streamer.sv
// Scans the drawing canvas in row-major order and streams one
// saturated pixel per valid/ready transfer.
module canvas_streamer #(
  parameter int DIM      = 28,
  parameter int WIDTH    = 16,
  parameter int CLIP_MAX = 2047
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0] canvas,
  canvas_streamer_if.master px,
  output logic Busy,
  output logic Done
);
  localparam int CW = $clog2(DIM);
  localparam logic [CW-1:0] XMAX = CW'(DIM - 1);
  localparam logic [9:0] LAST = 10'(DIM * DIM - 1);
  localparam logic [9:0] DIM10 = 10'(DIM);
  localparam logic [WIDTH-1:0] CLIP = WIDTH'(CLIP_MAX);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [CW-1:0] nx, ny;
  logic [9:0] nidx;

  logic [WIDTH-1:0] pix_q, pix_d;
  logic [9:0] idx_q, idx_d;
  logic valid_q, valid_d;
  logic last_q, last_d;

  function automatic logic [WIDTH-1:0] sat(
    input logic [WIDTH-1:0] v
  );
    return (v > CLIP) ? CLIP : v;
  endfunction

  // Next raster position and its linear index.
  always_comb begin
    nx = x_q + CW'(1);
    ny = y_q;
    if (x_q == XMAX) begin
      nx = '0;
      ny = y_q + CW'(1);
    end
    nidx = 10'(ny) * DIM10 + 10'(nx);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          x_d     = '0;
          y_d     = '0;
          pix_d   = sat(canvas[0][0]);
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = (LAST == 10'd0);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (px.Pixel_Ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            x_d    = nx;
            y_d    = ny;
            pix_d  = sat(canvas[nx][ny]);
            idx_d  = nidx;
            last_d = (nidx == LAST);
          end
        end
      end
      DONE: begin
        x_d     = '0;
        y_d     = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign px.Pixel_Out   = pix_q;
  assign px.Pixel_Index = idx_q;
  assign px.Pixel_Valid = valid_q;
  assign px.Pixel_Last  = last_q;
  assign Busy = (state_q == STREAM);
  assign Done = (state_q == DONE);
endmodule

// File: tb/tb_canvas_streamer.sv
// Scoreboard bench: the driver queues expected pixels, the
// monitor pops them on every accepted transfer.
module tb_canvas_streamer;
  localparam int DIM = 28;
  localparam int N = DIM * DIM;

  typedef struct {
    logic [15:0] v;
    logic [9:0]  i;
    logic        l;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic [DIM-1:0][DIM-1:0][15:0] canvas;

  canvas_streamer_if bus ();

  canvas_streamer dut (
    .Clk    (clk),
    .Reset  (rst),
    .Start  (start),
    .canvas (canvas),
    .px     (bus),
    .Busy   (busy),
    .Done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  logic [15:0] expv [N];

  int total = 0;
  int passed = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  bit done_pend = 0;
  bit hold_pend = 0;
  exp_t held;

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) passed++;
    else
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done_pend) begin
        check("done_after_last", 32'(done), 32'd1);
        done_pend = 0;
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (hold_pend) begin
        check("stall_valid", 32'(bus.Pixel_Valid), 1);
        check("stall_out", 32'(bus.Pixel_Out),
              32'(held.v));
        check("stall_idx", 32'(bus.Pixel_Index),
              32'(held.i));
        check("stall_last", 32'(bus.Pixel_Last),
              32'(held.l));
      end
      if (bus.Pixel_Valid && bus.Pixel_Ready) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL extra_xfer: got index %0d, expected none",
                   bus.Pixel_Index);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pix_out", 32'(bus.Pixel_Out), 32'(e.v));
          check("pix_idx", 32'(bus.Pixel_Index), 32'(e.i));
          check("pix_last", 32'(bus.Pixel_Last), 32'(e.l));
        end
        if (bus.Pixel_Last) done_pend = 1;
      end
      hold_pend = bus.Pixel_Valid && !bus.Pixel_Ready;
      held.v = bus.Pixel_Out;
      held.i = bus.Pixel_Index;
      held.l = bus.Pixel_Last;
    end
  end

  task automatic set_plain();
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) begin
        canvas[x][y] = 16'(y * DIM + x);
        expv[y * DIM + x] = 16'(y * DIM + x);
      end
  endtask

  task automatic push_all();
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.v = expv[i];
      e.i = 10'(i);
      e.l = (i == N - 1);
      q.push_back(e);
    end
  endtask

  // Entered and left at posedge+1; leaves in the IDLE cycle
  // right after Done so a new Start can follow immediately.
  task automatic run_scan(input bit rnd, input bit poke);
    int cyc;
    bit p10;
    bit p500;
    cyc = 0;
    p10 = 0;
    p500 = 0;
    push_all();
    busy_cnt = 0;
    done_cnt = 0;
    bus.Pixel_Ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_valid", 32'(bus.Pixel_Valid), 1);
    check("first_idx", 32'(bus.Pixel_Index), 0);
    check("busy_on", 32'(busy), 1);
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rnd) bus.Pixel_Ready = 1'($urandom_range(0, 1));
      if (poke) begin
        if (start) start = 1'b0;
        else if (busy && bus.Pixel_Index == 10 && !p10) begin
          start = 1'b1;
          p10 = 1;
        end else if (busy && bus.Pixel_Index == 500
                     && !p500) begin
          start = 1'b1;
          p500 = 1;
        end
      end
    end
    start = 1'b0;
    bus.Pixel_Ready = 1'b1;
    check("done_count", 32'(done_cnt), 1);
    check("queue_drained", 32'(q.size()), 0);
    check("done_dropped", 32'(done), 0);
    check("busy_off", 32'(busy), 0);
    if (!rnd) check("busy_cycles", 32'(busy_cnt), N);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    bus.Pixel_Ready = 1'b0;
    set_plain();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.Pixel_Valid), 0);
    check("rst_out", 32'(bus.Pixel_Out), 0);
    check("rst_idx", 32'(bus.Pixel_Index), 0);
    check("rst_last", 32'(bus.Pixel_Last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_valid", 32'(bus.Pixel_Valid), 0);

    run_scan(0, 0);
    run_scan(0, 0);

    canvas[5][3] = 16'hFFFF;
    canvas[6][3] = 16'd2047;
    expv[89] = 16'd2047;
    expv[90] = 16'd2047;
    run_scan(1, 0);

    set_plain();
    run_scan(0, 1);

    push_all();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (bus.Pixel_Index != 10'd300 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reached_300", 32'(bus.Pixel_Index), 300);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.Pixel_Valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_idx", 32'(bus.Pixel_Index), 0);
    check("arst_last", 32'(bus.Pixel_Last), 0);
    q.delete();
    hold_pend = 0;
    done_pend = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_scan(0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
